instr_loader: RTL and testbench

Program loader that fills the CPU's 256×9-bit instruction memory from a byte stream before execution. It sits between a host byte source (valid/ready) and the instruction memory write port, and drives the write side of the memory the control unit fetches from. It frames each 9-bit instruction as two bytes, writes words at consecutive addresses from 0, and holds the CPU in reset until the load completes.

---
 rtl/instr_loader.sv | 150 +++++++++++++++
 tb/tb_instr_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader
//   Fills the CPU's 256x9 instruction memory from a host byte stream and keeps
//   the CPU control unit in reset until the whole program has been written.
//
//   Stream: count byte C (N = C+1 words), then N pairs HI, LO.
//     HI = {1'b1, 6'b0, instr[8]}   LO = instr[7:0]
//   Words are written to consecutive addresses starting at 0.
//
//   Handshake: a byte moves on a rising clk edge where in_valid & in_ready.
//   in_ready depends only on the state. in_valid while in_ready=0 is ignored,
//   and that byte stays with the host.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high
//   start      one-cycle pulse; begins a load from IDLE, DONE or ERR
//   in_data    host byte
//   in_valid   host byte valid
//   in_ready   loader can accept a byte (COUNT, HI, LO)
//   mem_we     one-cycle write strobe per word
//   mem_addr   write address (register)
//   mem_wdata  write data {opcode[2:0], ra1, ra2, wa} (register)
//   cpu_hold   holds the CPU control unit in reset (low only in DONE)
//   busy       load in progress (COUNT, HI, LO, WRITE)
//   load_done  level; the full program is written
//   err        level; bad HI marker, load aborted
//   dbg_state  current FSM state encoding
module instr_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [8:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [8:0]        r_wdata;
  logic [7:0]        r_remaining;   // words still to write after the current one

  logic w_xfer;
  logic w_marker_ok;
  logic w_start_ok;

  assign w_xfer      = in_valid & in_ready;
  assign w_marker_ok = in_data[7] & (in_data[6:1] == 6'd0);
  // A start pulse only restarts from a resting state; mid-load it is dropped.
  assign w_start_ok  = start & ((r_state == S_IDLE) | (r_state == S_DONE) |
                                (r_state == S_ERR));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_COUNT;
      S_COUNT: if (w_xfer) w_next = S_HI;
      S_HI:    if (w_xfer) w_next = w_marker_ok ? S_LO : S_ERR;
      S_LO:    if (w_xfer) w_next = S_WRITE;
      S_WRITE: w_next = (r_remaining == 8'd0) ? S_DONE : S_HI;
      S_DONE:  if (w_start_ok) w_next = S_COUNT;
      S_ERR:   if (w_start_ok) w_next = S_COUNT;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    cpu_hold  = 1'b1;
    busy      = 1'b0;
    load_done = 1'b0;
    err       = 1'b0;
    case (r_state)
      S_COUNT, S_HI, S_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
      end
      S_DONE: begin
        load_done = 1'b1;
        cpu_hold  = 1'b0;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  // Datapath: address, write data and remaining-word counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_wdata     <= 9'd0;
      r_remaining <= 8'd0;
    end else begin
      case (r_state)
        S_COUNT: if (w_xfer) begin
          r_remaining <= in_data;
          r_addr      <= '0;
        end
        S_HI: if (w_xfer && w_marker_ok) r_wdata[8] <= in_data[0];
        S_LO: if (w_xfer) r_wdata[7:0] <= in_data;
        S_WRITE: begin
          // After the last word the address stays on it (no wrap to 0).
          if (r_remaining != 8'd0) begin
            r_remaining <= r_remaining - 8'd1;
            r_addr      <= r_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [8:0] mem_wdata;
  logic       cpu_hold;
  logic       busy;
  logic       load_done;
  logic       err;
  logic [2:0] dbg_state;

  instr_loader #(.ADDR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .load_done (load_done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int s_cyc    = 0;
  logic [16:0] exp_q[$];     // {addr[7:0], data[8:0]} in expected write order
  logic [8:0]  words[$];     // program for load_prog

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every write strobe must match the next word the host stream completed.
  always @(negedge clk) begin : cmp
    logic [16:0] e;
    if (!reset && mem_we) begin
      n_writes++;
      chk("write_busy", busy, 1);
      chk("write_hold", cpu_hold, 1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                 mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", mem_addr, e[16:9]);
        chk("write_data", mem_wdata, e[8:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All drives happen 1 time unit after a rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int t;
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 40) begin
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout: byte 0x%0h not accepted, in_ready=%0b", b, in_ready);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // A completed HI/LO pair produces exactly one write of that word at index i.
  task automatic send_word(input int i, input logic [8:0] w, input int max_gap);
    exp_q.push_back({8'(i), w});
    send_byte({7'b1000000, w[8]}, max_gap);
    send_byte(w[7:0], max_gap);
  endtask

  task automatic load_prog(input int max_gap);
    send_byte(8'(words.size() - 1), max_gap);
    for (int i = 0; i < words.size(); i++) send_word(i, words[i], max_gap);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (load_done || err) break;
      t++;
      if (t > 50) begin
        n_checks++;
        n_errors++;
        $display("FAIL done_timeout: load_done=%0b err=%0b", load_done, err);
        break;
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  in_ready,  0);
    chk({tag, "_mem_we"},    mem_we,    0);
    chk({tag, "_mem_addr"},  mem_addr,  0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_cpu_hold"},  cpu_hold,  1);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_load_done"}, load_done, 0);
    chk({tag, "_err"},       err,       0);
  endtask

  task automatic chk_done(input string tag, input int w0, input int n);
    chk({tag, "_load_done"}, load_done, 1);
    chk({tag, "_cpu_hold"},  cpu_hold,  0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_err"},       err,       0);
    chk({tag, "_in_ready"},  in_ready,  0);
    chk({tag, "_nwrites"},   n_writes - w0, n);
    chk({tag, "_q_empty"},   exp_q.size(), 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int w0;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("idle");

    // Basic load, expectations written out by hand.
    w0 = n_writes;
    pulse_start();
    chk("basic_count_ready", in_ready, 1);
    chk("basic_count_busy",  busy,     1);
    chk("basic_count_hold",  cpu_hold, 1);
    exp_q.push_back({8'h00, 9'h123});
    exp_q.push_back({8'h01, 9'h045});
    send_byte(8'h01, 0);
    send_byte(8'h81, 0);
    send_byte(8'h23, 0);
    send_byte(8'h80, 0);
    send_byte(8'h45, 0);
    wait_done();
    chk_done("basic", w0, 2);
    chk("basic_last_addr", mem_addr, 8'h01);

    // Framing error: HI byte 0x41 lacks the marker.
    w0 = n_writes;
    pulse_start();
    chk("frame_hold_restart", cpu_hold, 1);
    chk("frame_done_clear",   load_done, 0);
    send_byte(8'h00, 0);
    send_byte(8'h41, 0);
    @(negedge clk);
    chk("frame_err",      err,      1);
    chk("frame_ready",    in_ready, 0);
    chk("frame_hold",     cpu_hold, 1);
    chk("frame_busy",     busy,     0);
    chk("frame_done",     load_done, 0);
    chk("frame_nwrites",  n_writes - w0, 0);
    // Bytes offered in ERR must not be taken.
    in_data = 8'h80; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("frame_err_held", err, 1);
    @(posedge clk); #1; in_valid = 1'b0;
    // Recovery
    words = '{9'h1FF, 9'h000, 9'h0A5};
    w0 = n_writes;
    pulse_start();
    chk("recover_err_clear", err, 0);
    chk("recover_ready",     in_ready, 1);
    load_prog(0);
    wait_done();
    chk_done("recover", w0, 3);

    // Full depth with continuous valid; exact cycle count.
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back(9'(i) ^ 9'h1AA);
    w0 = n_writes;
    pulse_start();
    load_prog(0);
    wait_done();
    chk_done("full", w0, 256);
    // start edge, COUNT cycle, 3 cycles x 256 words => DONE seen 769 edges later
    chk("full_cycles",    cyc - s_cyc, 769);
    chk("full_last_addr", mem_addr, 8'hFF);
    chk("full_last_data", mem_wdata, 9'hFF ^ 9'h1AA);

    // Backpressure: random gaps, valid held through WRITE cycles.
    words.delete();
    for (int i = 0; i < 12; i++) words.push_back(9'($urandom_range(0, 511)));
    w0 = n_writes;
    pulse_start();
    load_prog(3);
    wait_done();
    chk_done("stall", w0, 12);

    // Reset while in LO of word 5.
    w0 = n_writes;
    pulse_start();
    send_byte(8'd7, 0);
    for (int i = 0; i < 5; i++) send_word(i, 9'(9'h100 + 9'(i * 17)), 1);
    send_byte(8'h81, 0);    // HI of word 5; now in LO
    chk("rst_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_nwrites", n_writes - w0, 5);
    chk("midrst_q_empty", exp_q.size(), 0);
    chk("midrst_idle_ready", in_ready, 0);

    // Start during HI is ignored.
    words = '{9'h0F0, 9'h10F};
    w0 = n_writes;
    pulse_start();
    send_byte(8'h01, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_busy",  busy,     1);
    chk("ign_ready", in_ready, 1);
    chk("ign_err",   err,      0);
    send_word(0, words[0], 0);
    send_word(1, words[1], 0);
    wait_done();
    chk_done("ign", w0, 2);

    // Reload after DONE with a single word.
    w0 = n_writes;
    pulse_start();
    chk("reload_hold", cpu_hold, 1);
    chk("reload_done", load_done, 0);
    words = '{9'h155};
    load_prog(0);
    wait_done();
    chk_done("reload", w0, 1);
    chk("reload_addr", mem_addr, 8'h00);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
